// File: rtl/mure_pkg.sv
// Shared micro-op types for the retirement front end.
package mure_pkg;

  localparam int ITYPE_LEN = 3;

  // itype 0 is a standard instruction, values above 2 are branches/jumps.
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;

  typedef struct packed {
    logic                 valid;
    logic [31:0]          pc;
    logic [ITYPE_LEN-1:0] itype;
    logic                 compressed;
    logic [1:0]           priv;
  } uop_entry_s;

endpackage

// File: rtl/slot_finder.sv
// Finds the lowest live slot at or above sel and whether it ends the row.
module slot_finder #(
  parameter int unsigned NRET = 2
) (
  input  logic [$clog2(NRET)-1:0] sel_i,
  input  logic [NRET-1:0]         live_i,
  input  logic [NRET-1:0]         special_i,
  output logic                    found_o,
  output logic [$clog2(NRET)-1:0] idx_o,
  output logic                    last_o
);

  localparam int unsigned SW = $clog2(NRET);

  logic higher;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(NRET) - 1; i >= 0; i--) begin
      if (live_i[i] && (SW'(i) >= sel_i)) begin
        found_o = 1'b1;
        idx_o   = SW'(i);
      end
    end
    higher = 1'b0;
    for (int i = 0; i < int'(NRET); i++) begin
      if (live_i[i] && (SW'(i) > idx_o)) higher = 1'b1;
    end
    // A special slot ends the row; anything behind it is discarded.
    last_o = special_i[idx_o] || !higher;
  end

endmodule

// File: rtl/uop_sequencer.sv
// Serialises one row of per-port retired uops into a single uop stream.
// state    | meaning
// IDLE     | no row being issued, waiting for row_valid_i
// ISSUE    | presenting live slots of the head row, popping on last/flush
module uop_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned NRET = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    row_valid_i,
  input  uop_entry_s [NRET-1:0]   row_i,
  output logic                    row_pop_o,
  input  logic                    flush_i,
  output logic                    uop_valid_o,
  output uop_entry_s              uop_o,
  input  logic                    uop_ready_i,
  output logic [$clog2(NRET)-1:0] sel_o,
  output logic [$clog2(NRET):0]   row_cnt_o,
  output logic                    busy_o
);

  localparam int unsigned SW = $clog2(NRET);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;
  localparam logic [SW-1:0] SEL_ONE = SW'(1);
  localparam logic [SW:0]   CNT_ONE = (SW + 1)'(1);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW:0]   cnt_q, cnt_d;

  logic [NRET-1:0] live, special;
  logic            found, last;
  logic [SW-1:0]   idx;

  always_comb begin
    live    = '0;
    special = '0;
    for (int i = 0; i < int'(NRET); i++) begin
      special[i] = (row_i[i].itype == ITYPE_EXC) || (row_i[i].itype == ITYPE_INT);
      live[i]    = special[i] || row_i[i].valid;
    end
  end

  slot_finder #(.NRET(NRET)) u_slot_finder (
    .sel_i     (sel_q),
    .live_i    (live),
    .special_i (special),
    .found_o   (found),
    .idx_o     (idx),
    .last_o    (last)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    uop_valid_o = 1'b0;
    uop_o       = '0;
    row_pop_o   = 1'b0;
    row_cnt_o   = '0;
    sel_o       = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (row_valid_i) begin
          state_d = ST_ISSUE;
          sel_d   = '0;
        end
      end
      default: begin
        if (!row_valid_i) begin
          // Nothing left after the previous pop; never pop an empty FIFO.
          state_d = ST_IDLE;
          sel_d   = '0;
          cnt_d   = '0;
        end else if (flush_i) begin
          row_pop_o = 1'b1;
          row_cnt_o = cnt_q;
          state_d   = ST_IDLE;
          sel_d     = '0;
          cnt_d     = '0;
        end else if (!found) begin
          row_pop_o = 1'b1;
          sel_d     = '0;
          cnt_d     = '0;
        end else begin
          uop_valid_o = 1'b1;
          uop_o       = row_i[idx];
          sel_o       = idx;
          if (uop_ready_i) begin
            if (last) begin
              row_pop_o = 1'b1;
              row_cnt_o = cnt_q + CNT_ONE;
              sel_d     = '0;
              cnt_d     = '0;
            end else begin
              sel_d = idx + SEL_ONE;
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end
    endcase
  end

  assign busy_o = (state_q == ST_ISSUE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer with NRET=2: directed table, corner sequences, random vs model.
module tb_uop_sequencer;
  import mure_pkg::*;

  localparam int NRET = 2;
  typedef uop_entry_s [NRET-1:0] row_t;

  typedef struct {
    logic       rv;
    logic       v0;
    logic [2:0] t0;
    logic       v1;
    logic [2:0] t1;
    logic       rdy;
    logic       fl;
    logic       ev;
    logic       esel;
    logic       epop;
    logic [1:0] ecnt;
    logic       ebusy;
  } vec_t;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       row_valid_i = 1'b0;
  row_t       row_i = '0;
  logic       row_pop_o;
  logic       flush_i = 1'b0;
  logic       uop_valid_o;
  uop_entry_s uop_o;
  logic       uop_ready_i = 1'b0;
  logic [0:0] sel_o;
  logic [1:0] row_cnt_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_err = 0;

  uop_sequencer #(.NRET(NRET)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .row_valid_i (row_valid_i),
    .row_i       (row_i),
    .row_pop_o   (row_pop_o),
    .flush_i     (flush_i),
    .uop_valid_o (uop_valid_o),
    .uop_o       (uop_o),
    .uop_ready_i (uop_ready_i),
    .sel_o       (sel_o),
    .row_cnt_o   (row_cnt_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic row_t mkrow(input logic v0, input logic [2:0] t0,
                                 input logic v1, input logic [2:0] t1);
    row_t r;
    r[0] = '{valid: v0, pc: 32'h0000_1000, itype: t0, compressed: 1'b1, priv: 2'd3};
    r[1] = '{valid: v1, pc: 32'h0000_1004, itype: t1, compressed: 1'b0, priv: 2'd1};
    return r;
  endfunction

  function automatic vec_t mkv(input logic rv, input logic v0, input logic [2:0] t0,
                               input logic v1, input logic [2:0] t1,
                               input logic rdy, input logic fl, input logic ev,
                               input logic esel, input logic epop,
                               input logic [1:0] ecnt, input logic ebusy);
    vec_t v;
    v.rv = rv; v.v0 = v0; v.t0 = t0; v.v1 = v1; v.t1 = t1;
    v.rdy = rdy; v.fl = fl; v.ev = ev; v.esel = esel;
    v.epop = epop; v.ecnt = ecnt; v.ebusy = ebusy;
    return v;
  endfunction

  // Slots a row hands over, in order: live slots, truncated after the first special one.
  function automatic void issue_list(input row_t r, output int lst[NRET], output int n);
    n = 0;
    for (int i = 0; i < NRET; i++) lst[i] = 0;
    for (int i = 0; i < NRET; i++) begin
      bit spec;
      spec = (r[i].itype == 3'd1) || (r[i].itype == 3'd2);
      if (spec || r[i].valid) begin
        lst[n] = i;
        n++;
      end
      if (spec) break;
    end
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < NRET; i++) begin
      r[i].valid      = 1'($urandom_range(0, 3) != 0);
      r[i].pc         = $urandom;
      r[i].itype      = 3'($urandom_range(0, 5));
      r[i].compressed = 1'($urandom_range(0, 1));
      r[i].priv       = 2'($urandom_range(0, 3));
    end
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[14];
  row_t hold_row;
  row_t q[$];
  bit   m_issue;
  int   m_k;

  initial begin
    tbl[0]  = mkv(1, 1,0, 1,4, 1,0, 0,0,0,0,0);
    tbl[1]  = mkv(1, 1,0, 1,4, 1,0, 1,0,0,0,1);
    tbl[2]  = mkv(1, 1,0, 1,4, 1,0, 1,1,1,2,1);
    tbl[3]  = mkv(1, 0,0, 1,0, 1,0, 1,1,1,1,1);
    tbl[4]  = mkv(1, 1,1, 1,0, 1,0, 1,0,1,1,1);
    tbl[5]  = mkv(1, 0,0, 0,0, 1,0, 0,0,1,0,1);
    tbl[6]  = mkv(1, 1,0, 1,0, 1,0, 1,0,0,0,1);
    tbl[7]  = mkv(1, 1,0, 1,0, 1,0, 1,1,1,2,1);
    tbl[8]  = mkv(1, 1,0, 1,0, 1,0, 1,0,0,0,1);
    tbl[9]  = mkv(1, 1,0, 1,0, 1,0, 1,1,1,2,1);
    tbl[10] = mkv(0, 0,0, 0,0, 1,0, 0,0,0,0,1);
    tbl[11] = mkv(0, 0,0, 0,0, 1,0, 0,0,0,0,0);
    tbl[12] = mkv(0, 0,0, 0,0, 1,1, 0,0,0,0,0);
    tbl[13] = mkv(1, 1,0, 1,0, 1,1, 0,0,0,0,0);

    // Reset state
    #2;
    chk("rst_valid", uop_valid_o, 0);
    chk("rst_pop", row_pop_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_sel", sel_o, 0);
    chk("rst_cnt", row_cnt_o, 0);
    chk("rst_uop", uop_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      row_t r;
      r = mkrow(tbl[i].v0, tbl[i].t0, tbl[i].v1, tbl[i].t1);
      row_valid_i = tbl[i].rv;
      row_i       = tbl[i].rv ? r : '0;
      uop_ready_i = tbl[i].rdy;
      flush_i     = tbl[i].fl;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_valid", i), uop_valid_o, tbl[i].ev);
      chk($sformatf("tbl%0d_pop", i), row_pop_o, tbl[i].epop);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].ebusy);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_sel", i), sel_o, tbl[i].esel);
        chk($sformatf("tbl%0d_uop", i), uop_o, r[tbl[i].esel]);
      end
      if (tbl[i].epop) chk($sformatf("tbl%0d_cnt", i), row_cnt_o, tbl[i].ecnt);
      next_cycle();
    end

    // Stall three cycles on s0, then flush
    hold_row    = mkrow(1, 0, 1, 0);
    row_valid_i = 1'b1;
    row_i       = hold_row;
    uop_ready_i = 1'b0;
    flush_i     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("stall%0d_valid", c), uop_valid_o, 1);
      chk($sformatf("stall%0d_sel", c), sel_o, 0);
      chk($sformatf("stall%0d_uop", c), uop_o, hold_row[0]);
      chk($sformatf("stall%0d_pop", c), row_pop_o, 0);
      next_cycle();
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_valid", uop_valid_o, 0);
    chk("flush_pop", row_pop_o, 1);
    chk("flush_cnt", row_cnt_o, 0);
    next_cycle();
    flush_i     = 1'b0;
    uop_ready_i = 1'b1;
    @(negedge clk_i);
    chk("postflush_busy", busy_o, 0);
    chk("postflush_valid", uop_valid_o, 0);
    next_cycle();

    // Reset after the s0 transfer: no pop, s0 reissued afterwards
    @(negedge clk_i);
    chk("prerst_valid", uop_valid_o, 1);
    chk("prerst_sel", sel_o, 0);
    chk("prerst_pop", row_pop_o, 0);
    next_cycle();
    rst_ni = 1'b0;
    #1;
    chk("midrst_pop", row_pop_o, 0);
    chk("midrst_valid", uop_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_sel", sel_o, 0);
    chk("midrst_cnt", row_cnt_o, 0);
    chk("midrst_uop", uop_o, 0);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rel_busy", busy_o, 0);
    next_cycle();
    @(negedge clk_i);
    chk("reiss_valid", uop_valid_o, 1);
    chk("reiss_sel", sel_o, 0);
    chk("reiss_uop", uop_o, hold_row[0]);
    chk("reiss_pop", row_pop_o, 0);
    next_cycle();

    // Random traffic against the row-level model
    rst_ni      = 1'b0;
    row_valid_i = 1'b0;
    row_i       = '0;
    next_cycle();
    rst_ni  = 1'b1;
    m_issue = 0;
    m_k     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit         e_v, e_pop, e_busy;
      int         e_sel;
      int         e_cnt;
      uop_entry_s e_uop;
      int         lst[NRET];
      int         n;
      if (q.size() < 4 && $urandom_range(0, 2) == 0) q.push_back(rand_row());
      row_valid_i = (q.size() > 0);
      row_i       = (q.size() > 0) ? q[0] : '0;
      uop_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 19) == 0);
      @(negedge clk_i);
      e_v = 0; e_pop = 0; e_sel = 0; e_cnt = 0; e_uop = '0; e_busy = m_issue;
      if (!m_issue) begin
        if (row_valid_i) begin
          m_issue = 1;
          m_k     = 0;
        end
      end else if (!row_valid_i) begin
        m_issue = 0;
        m_k     = 0;
      end else if (flush_i) begin
        e_pop = 1;
        e_cnt = m_k;
        void'(q.pop_front());
        m_issue = 0;
        m_k     = 0;
      end else begin
        issue_list(q[0], lst, n);
        if (n == 0) begin
          e_pop = 1;
          void'(q.pop_front());
        end else begin
          e_v   = 1;
          e_sel = lst[m_k];
          e_uop = q[0][lst[m_k]];
          if (uop_ready_i) begin
            m_k++;
            if (m_k == n) begin
              e_pop = 1;
              e_cnt = n;
              void'(q.pop_front());
              m_k = 0;
            end
          end
        end
      end
      chk($sformatf("rnd%0d_valid", cyc), uop_valid_o, e_v);
      chk($sformatf("rnd%0d_pop", cyc), row_pop_o, e_pop);
      chk($sformatf("rnd%0d_busy", cyc), busy_o, e_busy);
      if (e_v) begin
        chk($sformatf("rnd%0d_sel", cyc), sel_o, 64'(e_sel));
        chk($sformatf("rnd%0d_uop", cyc), uop_o, e_uop);
      end
      if (e_pop) chk($sformatf("rnd%0d_cnt", cyc), row_cnt_o, 64'(e_cnt));
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
